// File: rtl/cpu_dma_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_dma_pkg
// Brief   : Shared state encoding, default addresses and bus-owner selects
//           for the CPU / page-copy DMA bus arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } state_t;

   localparam logic [15:0] DEFAULT_TRIGGER_ADDR = 16'h4014;
   localparam logic [15:0] DEFAULT_DEST_ADDR    = 16'h2004;

   // Who owns the system bus this cycle
   localparam logic [1:0] BUS_SEL_CPU    = 2'd0;
   localparam logic [1:0] BUS_SEL_DUMMY  = 2'd1;
   localparam logic [1:0] BUS_SEL_DMA_RD = 2'd2;
   localparam logic [1:0] BUS_SEL_DMA_WR = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cpu_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cpu_dma_arbiter
// Brief   : Halts the 6502 on a trigger write and copies one 256-byte page
//           to a fixed destination port, then hands the bus back.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_dma_arbiter
   import cpu_dma_pkg::*;
#(
   parameter logic [15:0] TRIGGER_ADDR = DEFAULT_TRIGGER_ADDR,
   parameter logic [15:0] DEST_ADDR    = DEFAULT_DEST_ADDR,
   parameter bit          ALIGN_ENABLE = 1'b1
) (
   input  logic        clock,
   input  logic        nReset,
   input  logic        enable,
   input  logic [15:0] cpuAddress,
   input  logic [7:0]  cpuDataOut,
   input  logic        cpuWriteEnable,
   output logic        cpuEnable,
   output logic [7:0]  cpuDataIn,
   output logic [15:0] busAddress,
   output logic [7:0]  busDataOut,
   output logic        busWriteEnable,
   input  logic [7:0]  busDataIn,
   output logic        dmaActive
);

   state_t      state_q, state_d;
   logic [7:0]  page_q,  page_d;
   logic [7:0]  index_q, index_d;
   logic [7:0]  data_q,  data_d;
   logic        parity_q, parity_d;

   logic        trigger_hit;
   logic        cpu_go;
   logic [1:0]  bus_sel;

   assign trigger_hit = cpuWriteEnable && (cpuAddress == TRIGGER_ADDR);

   always_comb begin
      state_d  = state_q;
      page_d   = page_q;
      index_d  = index_q;
      data_d   = data_q;
      parity_d = parity_q;
      if (enable) begin
         parity_d = ~parity_q;
         case (state_q)
            ST_IDLE: begin
               if (trigger_hit) begin
                  page_d  = cpuDataOut;
                  index_d = 8'h00;
                  state_d = ST_HALT;
               end
            end
            ST_HALT: begin
               // CPU writes cannot be stretched, so only a read cycle is stolen
               if (!cpuWriteEnable) begin
                  state_d = (ALIGN_ENABLE && !parity_q) ? ST_ALIGN : ST_READ;
               end
            end
            ST_ALIGN: state_d = ST_READ;
            ST_READ: begin
               data_d  = busDataIn;
               state_d = ST_WRITE;
            end
            ST_WRITE: begin
               index_d = index_q + 8'd1;
               state_d = (index_q == 8'hFF) ? ST_IDLE : ST_READ;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state_q  <= ST_IDLE;
         page_q   <= 8'h00;
         index_q  <= 8'h00;
         data_q   <= 8'h00;
         parity_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         index_q  <= index_d;
         data_q   <= data_d;
         parity_q <= parity_d;
      end
   end

   always_comb begin
      bus_sel = BUS_SEL_CPU;
      cpu_go  = 1'b0;
      case (state_q)
         ST_IDLE:  cpu_go  = 1'b1;
         ST_HALT:  cpu_go  = cpuWriteEnable;
         ST_ALIGN: bus_sel = BUS_SEL_DUMMY;
         ST_READ:  bus_sel = BUS_SEL_DMA_RD;
         ST_WRITE: bus_sel = BUS_SEL_DMA_WR;
         default:  cpu_go  = 1'b0;
      endcase
   end

   always_comb begin
      busAddress     = cpuAddress;
      busDataOut     = cpuDataOut;
      busWriteEnable = cpuWriteEnable;
      case (bus_sel)
         BUS_SEL_DUMMY: busWriteEnable = 1'b0;
         BUS_SEL_DMA_RD: begin
            busAddress     = {page_q, index_q};
            busWriteEnable = 1'b0;
         end
         BUS_SEL_DMA_WR: begin
            busAddress     = DEST_ADDR;
            busDataOut     = data_q;
            busWriteEnable = 1'b1;
         end
         default: busWriteEnable = cpuWriteEnable;
      endcase
   end

   assign cpuEnable = enable && cpu_go;
   assign cpuDataIn = busDataIn;
   assign dmaActive = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cpu_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_dma_arbiter
// Brief   : Self-checking bench for cpu_dma_arbiter: pass-through vectors,
//           directed and randomized page copies against a transfer-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cpu_dma_arbiter;

   localparam logic [15:0] TRIG = 16'h4014;
   localparam logic [15:0] DEST = 16'h2004;

   logic        clock = 1'b0;
   logic        nReset = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] cpuAddress = 16'h0000;
   logic [7:0]  cpuDataOut = 8'h00;
   logic        cpuWriteEnable = 1'b0;
   logic        cpuEnable;
   logic [7:0]  cpuDataIn;
   logic [15:0] busAddress;
   logic [7:0]  busDataOut;
   logic        busWriteEnable;
   logic [7:0]  busDataIn;
   logic        dmaActive;

   logic [7:0]  mem [0:65535];

   int n_tests = 0;
   int n_fail  = 0;
   int en_cycles = 0;
   int stall = 0;
   logic [15:0] rd_q [$];
   logic [7:0]  wr_q [$];

   logic        obs_act, obs_cpuen, obs_we;
   logic [15:0] obs_addr;
   logic [7:0]  obs_dout, obs_din;

   cpu_dma_arbiter dut (
      .clock          (clock),
      .nReset         (nReset),
      .enable         (enable),
      .cpuAddress     (cpuAddress),
      .cpuDataOut     (cpuDataOut),
      .cpuWriteEnable (cpuWriteEnable),
      .cpuEnable      (cpuEnable),
      .cpuDataIn      (cpuDataIn),
      .busAddress     (busAddress),
      .busDataOut     (busDataOut),
      .busWriteEnable (busWriteEnable),
      .busDataIn      (busDataIn),
      .dmaActive      (dmaActive)
   );

   assign busDataIn = mem[busAddress];

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One bus cycle: drive, settle, observe and log DMA traffic, then clock.
   task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic we, input logic en);
      cpuAddress = a; cpuDataOut = d; cpuWriteEnable = we; enable = en;
      #2;
      obs_act = dmaActive; obs_cpuen = cpuEnable; obs_we = busWriteEnable;
      obs_addr = busAddress; obs_dout = busDataOut; obs_din = cpuDataIn;
      if (en && dmaActive && !cpuEnable) begin
         stall++;
         if (busWriteEnable && busAddress == DEST) wr_q.push_back(busDataOut);
         else if (!busWriteEnable) rd_q.push_back(busAddress);
      end
      if (en) en_cycles++;
      @(posedge clock); #1;
   endtask

   // Full transfer: trigger on a chosen parity, optional CPU writes, then
   // CPU reads until the bus comes back. Expectations come from the page
   // number, the parity of the stolen read and the memory image.
   task automatic run_dma(input logic [7:0] page, input int trig_par, input int n_wr,
                          input int pause_idx, input bit rand_en, input logic [15:0] ra);
      logic [15:0] exp_rd [$];
      int  halt_par, guard, errs, exp_stall, n;
      bit  seen_read, paused, last_en;
      logic en_now;
      while ((en_cycles % 2) != trig_par) cyc(16'h8000, 8'h00, 1'b0, 1'b1);
      rd_q.delete(); wr_q.delete(); stall = 0;
      cyc(TRIG, page, 1'b1, 1'b1);
      chk("trigger_passthrough", {obs_act, obs_cpuen, obs_we, obs_addr, obs_dout},
          {1'b0, 1'b1, 1'b1, TRIG, page});
      for (int k = 0; k < n_wr; k++) begin
         cyc(16'h01FD - 16'(k), 8'hA0 + 8'(k), 1'b1, 1'b1);
         chk("halt_cpu_write", {obs_act, obs_cpuen, obs_we}, 3'b111);
      end
      seen_read = 0; paused = 0; guard = 0; halt_par = 0; last_en = 1;
      while (guard < 3000) begin
         en_now = rand_en ? ($urandom_range(0, 7) != 0) : 1'b1;
         if (!seen_read && en_now) begin
            seen_read = 1;
            halt_par  = en_cycles % 2;
         end
         cyc(ra, 8'h00, 1'b0, en_now);
         last_en = en_now;
         guard++;
         if (!obs_act) break;
         if (pause_idx >= 0 && !paused && en_now && !obs_we &&
             obs_addr == {page, 8'(pause_idx)}) begin
            paused = 1;
            for (int p = 0; p < 10; p++) begin
               cyc(ra, 8'h00, 1'b0, 1'b0);
               chk("pause_hold", {obs_act, obs_cpuen, obs_we, obs_addr, obs_dout},
                   {1'b1, 1'b0, 1'b1, DEST, mem[{page, 8'(pause_idx)}]});
            end
         end
      end
      chk("xfer_done", obs_act, 1'b0);
      chk("end_cpu_enable", obs_cpuen, last_en);
      if (pause_idx >= 0) chk("pause_reached", paused, 1'b1);
      exp_stall = 513 + ((halt_par == 0) ? 1 : 0);
      chk("stall_cycles", stall, exp_stall);
      exp_rd.push_back(ra);
      if (halt_par == 0) exp_rd.push_back(ra);
      for (int i = 0; i < 256; i++) exp_rd.push_back({page, 8'(i)});
      chk("read_count", rd_q.size(), exp_rd.size());
      errs = 0;
      n = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
      for (int i = 0; i < n; i++) if (rd_q[i] !== exp_rd[i]) errs++;
      chk("read_sequence_errs", errs, 0);
      chk("write_count", wr_q.size(), 256);
      errs = 0;
      n = (wr_q.size() < 256) ? wr_q.size() : 256;
      for (int i = 0; i < n; i++) if (wr_q[i] !== mem[{page, 8'(i)}]) errs++;
      chk("write_data_errs", errs, 0);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      logic        we;
      logic        en;
      logic        exp_cpuen;
      logic        exp_act;
   } vec_t;

   vec_t vt [8];

   initial begin
      int guard;
      bit hit;
      logic [15:0] ra;
      logic [15:0] a;
      logic        we;

      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

      // Under reset: pass-through, cpuEnable follows enable
      enable = 1'b1; cpuAddress = 16'h1234; cpuDataOut = 8'hAB; cpuWriteEnable = 1'b1;
      #1;
      chk("reset_outputs", {cpuEnable, dmaActive, busAddress, busWriteEnable, busDataOut},
          {1'b1, 1'b0, 16'h1234, 1'b1, 8'hAB});
      enable = 1'b0; #1;
      chk("reset_enable_low", cpuEnable, 1'b0);
      repeat (3) @(posedge clock);
      #1 nReset = 1'b1;
      en_cycles = 0;

      vt[0] = '{16'h4015, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0};
      vt[1] = '{16'h4014, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[2] = '{16'h4014, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[3] = '{16'h8000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[4] = '{16'h4013, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0};
      vt[5] = '{16'h2004, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0};
      vt[6] = '{16'h4014, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[7] = '{16'h0000, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         cyc(vt[i].a, vt[i].d, vt[i].we, vt[i].en);
         chk($sformatf("vec%0d", i),
             {obs_cpuen, obs_act, obs_addr, obs_we, obs_dout, obs_din},
             {vt[i].exp_cpuen, vt[i].exp_act, vt[i].a, vt[i].we, vt[i].d, mem[vt[i].a]});
      end

      run_dma(8'h02, 0, 0, -1, 1'b0, 16'hC000);
      run_dma(8'h02, 1, 0, -1, 1'b0, 16'hC000);
      run_dma(8'h02, 0, 3, -1, 1'b0, 16'hC123);
      run_dma(8'hFF, 0, 0, -1, 1'b0, 16'hE000);
      run_dma(8'h37, 1, 0, 8'h40, 1'b0, 16'hC456);

      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < 6; k++) begin
            a  = 16'($urandom);
            we = 1'($urandom);
            if (a == TRIG) we = 1'b0;
            cyc(a, 8'($urandom), we, 1'b1);
            chk("rand_idle_passthrough", {obs_act, obs_cpuen, obs_addr, obs_we},
                {1'b0, 1'b1, a, we});
         end
         ra = 16'($urandom);
         run_dma(8'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 -1, 1'b1, ra);
      end

      // Reset during the read of index 8'h80 must abort at once
      while ((en_cycles % 2) != 0) cyc(16'h8000, 8'h00, 1'b0, 1'b1);
      cyc(TRIG, 8'h11, 1'b1, 1'b1);
      guard = 0; hit = 0;
      while (guard < 1000 && !hit) begin
         cpuAddress = 16'h9000; cpuDataOut = 8'h00; cpuWriteEnable = 1'b0; enable = 1'b1;
         #2;
         if (dmaActive && !busWriteEnable && busAddress == 16'h1180) begin
            nReset = 1'b0;
            #1;
            chk("abort_outputs", {busWriteEnable, dmaActive, cpuEnable, busAddress},
                {1'b0, 1'b0, 1'b1, 16'h9000});
            hit = 1;
         end else begin
            @(posedge clock); #1;
         end
         guard++;
      end
      chk("abort_reached", hit, 1'b1);
      repeat (2) @(posedge clock);
      #1 nReset = 1'b1;
      en_cycles = 0;
      rd_q.delete(); wr_q.delete(); stall = 0;
      repeat (600) cyc(16'h9000, 8'h00, 1'b0, 1'b1);
      chk("abort_no_dest_writes", wr_q.size(), 0);
      chk("abort_no_stall", stall, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
